// File: rtl/acc_seq_if.sv
// Bus bundle between the frame sequencer, its upstream sample stream,
// the external accumulator and the downstream result stream.
// The slave view belongs to acc_seq; the master view is the surrounding
// environment (sample source, accumulator, result sink).
interface acc_seq_if #(
  parameter int DIN_WIDTH  = 16,
  parameter int DOUT_WIDTH = 32
);
  // upstream sample stream
  logic [DIN_WIDTH-1:0]  s_tdata;
  logic                  s_tvalid;
  logic                  s_tready;
  // external accumulator control and result
  logic [DIN_WIDTH-1:0]  acc_din;
  logic                  acc_en;
  logic                  acc_last;
  logic                  acc_rst;
  logic [DOUT_WIDTH-1:0] acc_dout;
  logic                  acc_dout_valid;
  // downstream result stream
  logic [DOUT_WIDTH-1:0] m_tdata;
  logic                  m_tvalid;
  logic                  m_tready;

  modport slave (
    input  s_tdata, s_tvalid, acc_dout, acc_dout_valid, m_tready,
    output s_tready, acc_din, acc_en, acc_last, acc_rst, m_tdata, m_tvalid
  );

  modport master (
    output s_tdata, s_tvalid, acc_dout, acc_dout_valid, m_tready,
    input  s_tready, acc_din, acc_en, acc_last, acc_rst, m_tdata, m_tvalid
  );
endinterface

// File: rtl/acc_seq.sv
// Frame sequencer for an external accumulator: feeds N_SAMPLES signed
// samples per frame, flags the last one, waits a bounded time for the
// accumulator result, then hands the result downstream with backpressure.
module acc_seq #(
  parameter int DIN_WIDTH  = 16,
  parameter int DOUT_WIDTH = 32,
  parameter int N_SAMPLES  = 16,
  parameter int TIMEOUT    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  acc_seq_if.slave    bus,
  output logic        err,
  output logic [15:0] frame_cnt
);

  localparam int CNT_W  = $clog2(N_SAMPLES);
  localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    WAIT  = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t                state_r, state_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic [WCNT_W-1:0]     wcnt_r, wcnt_s;
  logic [DOUT_WIDTH-1:0] m_tdata_r, m_tdata_s;
  logic                  m_tvalid_r, m_tvalid_s;
  logic                  err_r, err_s;
  logic [15:0]           frame_cnt_r, frame_cnt_s;

  logic [DIN_WIDTH-1:0]  sample_s;
  logic                  s_tready_s;
  logic                  accept_s;
  logic                  last_cnt_s;

  // Handshake decode: ready only in ACCUM, and never while reset or an
  // abort is in progress so no sample is taken that the frame would lose.
  always_comb begin
    sample_s   = bus.s_tdata;
    s_tready_s = rst_n & ~clear & (state_r == ACCUM);
    accept_s   = bus.s_tvalid & s_tready_s;
    last_cnt_s = (cnt_r == CNT_W'(N_SAMPLES - 1));
  end

  assign bus.s_tready = s_tready_s;
  assign bus.acc_din  = sample_s;
  assign bus.acc_en   = accept_s & ~last_cnt_s;
  assign bus.acc_last = accept_s & last_cnt_s;
  assign bus.acc_rst  = clear | ~rst_n;
  assign bus.m_tdata  = m_tdata_r;
  assign bus.m_tvalid = m_tvalid_r;
  assign err          = err_r;
  assign frame_cnt    = frame_cnt_r;

  // Next-state and next-register values; abort overrides every state.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    wcnt_s      = wcnt_r;
    m_tdata_s   = m_tdata_r;
    m_tvalid_s  = m_tvalid_r;
    err_s       = err_r;
    frame_cnt_s = frame_cnt_r;
    if (clear) begin
      state_s    = ACCUM;
      cnt_s      = CNT_W'(0);
      wcnt_s     = WCNT_W'(0);
      m_tvalid_s = 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          wcnt_s = WCNT_W'(0);
          if (accept_s) begin
            if (last_cnt_s) begin
              cnt_s   = CNT_W'(0);
              state_s = WAIT;
            end else begin
              cnt_s = cnt_r + CNT_W'(1);
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
        WAIT: begin
          if (bus.acc_dout_valid) begin
            m_tdata_s  = bus.acc_dout;
            m_tvalid_s = 1'b1;
            wcnt_s     = WCNT_W'(0);
            state_s    = OUT;
          end else if (wcnt_r == WCNT_W'(TIMEOUT - 1)) begin
            err_s   = 1'b1;
            wcnt_s  = WCNT_W'(0);
            state_s = ACCUM;
          end else begin
            wcnt_s = wcnt_r + WCNT_W'(1);
          end
        end
        OUT: begin
          if (bus.m_tready) begin
            m_tvalid_s  = 1'b0;
            frame_cnt_s = frame_cnt_r + 16'd1;
            state_s     = ACCUM;
          end else begin
            state_s = OUT;
          end
        end
        default: begin
          state_s    = ACCUM;
          cnt_s      = CNT_W'(0);
          wcnt_s     = WCNT_W'(0);
          m_tvalid_s = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ACCUM;
      cnt_r       <= CNT_W'(0);
      wcnt_r      <= WCNT_W'(0);
      m_tdata_r   <= DOUT_WIDTH'(0);
      m_tvalid_r  <= 1'b0;
      err_r       <= 1'b0;
      frame_cnt_r <= 16'd0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      wcnt_r      <= wcnt_s;
      m_tdata_r   <= m_tdata_s;
      m_tvalid_r  <= m_tvalid_s;
      err_r       <= err_s;
      frame_cnt_r <= frame_cnt_s;
    end
  end

endmodule
